fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the Zeptron pipeline: the producer side of the `d_instr` interface that `decode_stage` consumes. It holds the fetch PC and issues word requests to instruction memory over a req/gnt + rvalid protocol. Returned words go into a small prefetch FIFO tagged with their PC, and are handed to decode with a valid/ready handshake. A redirect from branch/jump resolution flushes the FIFO, discards in-flight responses and restarts fetch at the new PC.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: prefetch FIFO entries; must be a power of 2 and at least 2.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word address of the request; bits [1:0] are always 0.
- `imem_gnt`  in  1  request accepted this cycle; ignored when `imem_req`=0.
- `imem_rvalid`  in  1  response valid; responses are in order, at least 1 cycle after their grant.
- `imem_rdata`  in  32  response instruction word.
- `redirect`  in  1  pipeline redirect (taken branch, jal, jalr).
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are forced to 0 internally.
- `d_valid`  out  1  `d_instr`/`d_pc` valid toward decode.
- `d_ready`  in  1  decode accepts this cycle.
- `d_instr`  out  32  instruction word at the FIFO head.
- `d_pc`  out  32  PC of `d_instr`.

## Operation
**State**
- `fetch_pc`: next address to request.
- `resp_pc`: PC of the next non-discarded response.
- `outstanding`: granted but unanswered requests; width $clog2(DEPTH)+1.
- `discard`: in-flight responses to drop; `discard` ≤ `outstanding`.
- FIFO `count`: entries held, each {instr, pc}.

**Issue**
- `imem_req` = !redirect && (count + outstanding < DEPTH). Credit uses registered values only; a pop in the same cycle frees credit from the next cycle.
- `imem_addr` = `fetch_pc`.
- On `imem_req && imem_gnt`: `fetch_pc` += 4 and `outstanding` +1.
- `imem_addr` is held stable while `imem_req` is high and not yet granted.

**Response**
- On `imem_rvalid`: `outstanding` -1.
- If `discard`>0, the word is dropped and `discard` -1.
- Otherwise {imem_rdata, resp_pc} is pushed and `resp_pc` += 4.
- A grant and a response in the same cycle leave `outstanding` unchanged.

**Output**
- `d_valid` = (count>0) && !redirect.
- `d_instr`/`d_pc` come from the head entry.
- A pop happens on `d_valid && d_ready`. Push and pop in the same cycle are allowed, including when full, because credit guarantees space.

**Redirect (priority over all else)**
- In the redirect cycle: `imem_req`=0, no pop, and any `imem_rvalid` is dropped.
- Next state: count=0, `fetch_pc`=`resp_pc`={redirect_pc[31:2],2'b00}, `discard` = `outstanding` − imem_rvalid, `outstanding` = `outstanding` − imem_rvalid.
- Back-to-back redirects: the last one wins, and `discard` is recomputed each time.

**Arithmetic**
- PC adds are modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Counters never overflow, because credit bounds `outstanding` to at most DEPTH.

## Timing
**Reset values**
- `imem_req`=0 while `rst_n`=0; `imem_addr`=RESET_PC.
- `d_valid`=0, `d_instr`=0, `d_pc`=0.
- All counters 0; FIFO storage 0; `fetch_pc`=`resp_pc`=RESET_PC.

**Reset behaviour**
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- Reset asserted mid-operation clears everything immediately. Responses that arrive after reset release while `outstanding`=0 are not permitted by the protocol and are not handled.

**Latency and throughput**
- Grant in cycle N, rvalid in N+1 gives `d_valid` in N+2. There is no bypass around the FIFO.
- With DEPTH≥3 and 1-cycle memory, sustained throughput is 1 instruction per cycle while `d_ready`=1.
- First valid instruction after a redirect in cycle R, with 1-cycle memory: request in R+1, `d_valid` in R+3.

**Backpressure**
- With `d_ready`=0, the FIFO fills and `imem_req` drops once count + outstanding = DEPTH.

## Test plan
- **Reset and stream:** release reset, memory grants immediately with rvalid the next cycle, rdata = address, `d_ready`=1.
  - Required: addresses 0,4,8,… issued every cycle.
  - Required: first `d_valid` 3 cycles after reset release, with `d_pc`=0, `d_instr`=0, then one entry per cycle with `d_pc`=`d_instr`.
- **Backpressure:** hold `d_ready`=0.
  - Required: exactly 4 grants, then `imem_req`=0.
  - Required: `d_pc`=0 stays stable; after `d_ready`=1, PCs 0,4,8,12 drain in order with no gap and fetch resumes at 16.
- **Redirect with in-flight responses:** memory latency 3 cycles, 2 outstanding, redirect to 32'h100.
  - Required: the 2 late responses are dropped.
  - Required: next `d_pc`=32'h100 and no stale PC ever appears on `d_valid`.
- **Misaligned, back-to-back redirects:** redirect to 32'h203, then 32'h400 the next cycle.
  - Required: first fetch at 32'h400, with `imem_addr`[1:0]=0 throughout.
- **Wrap-around:** redirect to 32'hFFFF_FFF8.
  - Required: `d_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Stalled grant and mid-stream reset:**
  - `imem_gnt` low for 5 cycles: `imem_addr` stays constant.
  - Assert `rst_n`=0 mid-stream: `d_valid` and `imem_req` drop to 0 asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the Zeptron pipeline. It owns the fetch PC,
// issues word requests to instruction memory over a req/gnt + rvalid protocol,
// and collects the returned words in a small prefetch FIFO. Each FIFO entry
// holds the instruction together with its PC. Decode pops entries with a
// valid/ready handshake. A redirect from branch/jump resolution has three
// effects: it flushes the FIFO, it marks every in-flight response for discard,
// and it restarts fetch at the new PC.
//
// Parameters
//   RESET_PC     first fetch address after reset (low two bits ignored)
//   DEPTH        prefetch FIFO entries; a power of 2, at least 2
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     out  fetch request valid
//   imem_addr    out  word address of the request ([1:0] always 0)
//   imem_gnt     in   request accepted this cycle (ignored while imem_req=0)
//   imem_rvalid  in   response valid; responses come back in request order
//   imem_rdata   in   response instruction word
//   redirect     in   pipeline redirect (taken branch, jal, jalr)
//   redirect_pc  in   new fetch PC ([1:0] forced to 0)
//   d_valid      out  d_instr/d_pc valid toward decode
//   d_ready      in   decode accepts the head entry this cycle
//   d_instr      out  instruction word at the FIFO head
//   d_pc         out  PC of d_instr
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // One extra bit so that count + outstanding (each at most DEPTH) cannot
    // wrap before it is compared against DEPTH.
    localparam logic [CNT_W:0] DEPTH_C    = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]    RESET_PC_A = RESET_PC & ~32'h3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // run_q is clear during reset and sets on the first clock edge after
    // release. Requests are gated with it, so imem_req is held low throughout
    // reset. It also drops immediately when reset is reasserted.
    logic              run_q,         run_d;
    logic [31:0]       fetch_pc_q,    fetch_pc_d;
    logic [31:0]       resp_pc_q,     resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q,     discard_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [31:0]       mem_instr_q [DEPTH];
    logic [31:0]       mem_instr_d [DEPTH];
    logic [31:0]       mem_pc_q    [DEPTH];
    logic [31:0]       mem_pc_d    [DEPTH];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic [CNT_W:0] credit_used;
    logic           grant;
    logic           pop;
    logic           push;
    logic           drop;
    logic [31:0]    redirect_pc_a;

    // Credit uses registered counts only. A pop in this cycle frees its slot
    // for issue from the next cycle onward. Because of this, a push always
    // has a free slot, even when it lands in the same cycle as a pop on a
    // full FIFO.
    assign credit_used   = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req      = run_q && !redirect && (credit_used < DEPTH_C);
    assign imem_addr     = fetch_pc_q;
    assign grant         = imem_req && imem_gnt;

    assign d_valid       = (count_q != '0) && !redirect;
    assign d_instr       = mem_instr_q[rd_ptr_q];
    assign d_pc          = mem_pc_q[rd_ptr_q];
    assign pop           = d_valid && d_ready;

    // A response arriving in a redirect cycle is dropped outright. It is
    // already excluded from the discard count computed for the next state.
    assign drop          = imem_rvalid && !redirect && (discard_q != '0);
    assign push          = imem_rvalid && !redirect && (discard_q == '0);

    assign redirect_pc_a = redirect_pc & ~32'h3;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path through this
        // block leaves a variable unassigned and no latch is inferred.
        run_d         = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mem_instr_d   = mem_instr_q;
        mem_pc_d      = mem_pc_q;

        if (redirect) begin
            // Redirect wins over everything. Nothing is granted or popped
            // this cycle. Every response still owed by memory becomes stale.
            fetch_pc_d    = redirect_pc_a;
            resp_pc_d     = redirect_pc_a;
            outstanding_d = outstanding_q - CNT_W'(imem_rvalid);
            discard_d     = outstanding_d;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end

            // A grant and a response in the same cycle cancel out.
            outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);

            if (drop) begin
                discard_d = discard_q - CNT_W'(1);
            end

            if (push) begin
                mem_instr_d[wr_ptr_q] = imem_rdata;
                mem_pc_d[wr_ptr_q]    = resp_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                resp_pc_d             = resp_pc_q + 32'd4;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments here. Every flop then samples the
            // pre-edge values, whatever order the statements appear in.
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC_A;
            resp_pc_q     <= RESET_PC_A;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            // NOTE: the FIFO storage is reset along with the control state.
            // d_instr and d_pc are then defined as zero out of reset, not X.
            mem_instr_q   <= '{default: '0};
            mem_pc_q      <= '{default: '0};
        end else begin
            run_q         <= run_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            mem_instr_q   <= mem_instr_d;
            mem_pc_q      <= mem_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small in-order memory model with
// programmable latency returns rdata = address, so every d_instr is expected
// to equal its d_pc. Cycle k means the k-th clock period after reset release.
// Inputs change and outputs are sampled a little after the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_instr;
    logic [31:0] d_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          lat      = 1;
    int          n_grants = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .d_instr     (d_instr),
        .d_pc        (d_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock. The task first captures the pre-edge handshake.
    // After the edge it lets the memory model answer in order, with each
    // response `lat` cycles after its grant.
    task automatic cyc();
        logic        g;
        logic [31:0] a;
        #1;
        g = rst_n && imem_req && imem_gnt;
        a = imem_addr;
        @(posedge clk);
        #1;
        cycle++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (g) begin
                pend_addr.push_back(a);
                pend_due.push_back(cycle + lat - 1);
                n_grants++;
            end
            if (pend_due.size() > 0 && pend_due[0] <= cycle) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr.pop_front();
                void'(pend_due.pop_front());
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n    = 1'b1;
        cycle    = 0;
        n_grants = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        d_ready     = 1'b1;
        lat         = 1;
        #2;

        // ---------------- reset values ----------------
        check("rst_req",    imem_req,  32'h0);
        check("rst_addr",   imem_addr, 32'h0);
        check("rst_dvalid", d_valid,   32'h0);
        check("rst_dinstr", d_instr,   32'h0);
        check("rst_dpc",    d_pc,      32'h0);
        cyc();

        // ---------------- reset release and stream ----------------
        rst_n = 1'b1;
        cycle = 0;
        cyc();
        check("str_req_c1",    imem_req,  32'h1);
        check("str_addr_c1",   imem_addr, 32'h0);
        check("str_dvalid_c1", d_valid,   32'h0);
        cyc();
        check("str_addr_c2",   imem_addr, 32'h4);
        check("str_dvalid_c2", d_valid,   32'h0);
        for (int k = 3; k <= 8; k++) begin
            cyc();
            check($sformatf("str_dvalid_c%0d", k), d_valid,   32'h1);
            check($sformatf("str_dpc_c%0d",    k), d_pc,      32'(4 * (k - 3)));
            check($sformatf("str_dinstr_c%0d", k), d_instr,   32'(4 * (k - 3)));
            check($sformatf("str_addr_c%0d",   k), imem_addr, 32'(4 * (k - 1)));
        end

        // ---------------- mid-stream reset, asynchronous ----------------
        rst_n = 1'b0;
        #1;
        check("mrst_req",    imem_req,  32'h0);
        check("mrst_dvalid", d_valid,   32'h0);
        check("mrst_addr",   imem_addr, 32'h0);
        check("mrst_dpc",    d_pc,      32'h0);

        // ---------------- backpressure ----------------
        d_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check($sformatf("bp_req_c%0d",  k), imem_req,  (k <= 4) ? 32'h1 : 32'h0);
            check($sformatf("bp_addr_c%0d", k), imem_addr, (k <= 4) ? 32'(4 * (k - 1)) : 32'h10);
            if (k >= 3) begin
                check($sformatf("bp_dvalid_c%0d", k), d_valid, 32'h1);
                check($sformatf("bp_dpc_c%0d",    k), d_pc,    32'h0);
            end
        end
        check("bp_grants", 32'(n_grants), 32'h4);
        d_ready = 1'b1;
        #1;
        check("bp_drain_req_c9", imem_req, 32'h0);
        for (int k = 10; k <= 14; k++) begin
            cyc();
            check($sformatf("bp_drain_dvalid_c%0d", k), d_valid, 32'h1);
            check($sformatf("bp_drain_dpc_c%0d",    k), d_pc,    32'(4 * (k - 9)));
            if (k == 10) begin
                check("bp_resume_req",  imem_req,  32'h1);
                check("bp_resume_addr", imem_addr, 32'h10);
            end
        end

        // ---------------- redirect with two late responses ----------------
        lat = 3;
        do_reset();
        cyc();
        cyc();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("rd_req_c3",    imem_req, 32'h0);
        check("rd_dvalid_c3", d_valid,  32'h0);
        cyc();
        redirect = 1'b0;
        #1;
        check("rd_req_c4",    imem_req,  32'h1);
        check("rd_addr_c4",   imem_addr, 32'h100);
        check("rd_dvalid_c4", d_valid,   32'h0);
        for (int k = 5; k <= 7; k++) begin
            cyc();
            check($sformatf("rd_dvalid_c%0d", k), d_valid, 32'h0);
        end
        for (int k = 8; k <= 11; k++) begin
            cyc();
            check($sformatf("rd_dvalid_c%0d", k), d_valid, 32'h1);
            check($sformatf("rd_dpc_c%0d",    k), d_pc,    32'h100 + 32'(4 * (k - 8)));
            check($sformatf("rd_dinstr_c%0d", k), d_instr, 32'h100 + 32'(4 * (k - 8)));
        end

        // ---------------- misaligned back-to-back redirects ----------------
        lat = 1;
        do_reset();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        #1;
        check("mis_req_c1", imem_req, 32'h0);
        cyc();
        redirect_pc = 32'h400;
        #1;
        check("mis_req_c2",  imem_req,  32'h0);
        check("mis_addr_c2", imem_addr, 32'h200);
        cyc();
        redirect = 1'b0;
        #1;
        check("mis_req_c3",  imem_req,  32'h1);
        check("mis_addr_c3", imem_addr, 32'h400);
        cyc();
        check("mis_addr_c4",   imem_addr,        32'h404);
        check("mis_grants_c4", 32'(n_grants),    32'h1);
        cyc();
        check("mis_dvalid_c5", d_valid, 32'h1);
        check("mis_dpc_c5",    d_pc,    32'h400);
        check("mis_dinstr_c5", d_instr, 32'h400);

        // ---------------- PC wrap-around ----------------
        do_reset();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        cyc();
        redirect = 1'b0;
        #1;
        check("wrap_addr_c2", imem_addr, 32'hFFFF_FFF8);
        cyc();
        check("wrap_addr_c3", imem_addr, 32'hFFFF_FFFC);
        cyc();
        check("wrap_addr_c4", imem_addr, 32'h0000_0000);
        check("wrap_dpc_c4",  d_pc,      32'hFFFF_FFF8);
        check("wrap_dins_c4", d_instr,   32'hFFFF_FFF8);
        cyc();
        check("wrap_dpc_c5",  d_pc,      32'hFFFF_FFFC);
        cyc();
        check("wrap_dval_c6", d_valid,   32'h1);
        check("wrap_dpc_c6",  d_pc,      32'h0000_0000);
        check("wrap_dins_c6", d_instr,   32'h0000_0000);

        // ---------------- stalled grant ----------------
        do_reset();
        cyc();
        cyc();
        cyc();
        check("stall_addr_c3", imem_addr, 32'h8);
        imem_gnt = 1'b0;
        for (int k = 4; k <= 8; k++) begin
            cyc();
            check($sformatf("stall_req_c%0d",  k), imem_req,  32'h1);
            check($sformatf("stall_addr_c%0d", k), imem_addr, 32'h8);
        end
        check("stall_dvalid_c8", d_valid, 32'h0);
        imem_gnt = 1'b1;
        cyc();
        check("stall_addr_c9", imem_addr, 32'hC);
        cyc();
        check("stall_dvalid_c10", d_valid, 32'h1);
        check("stall_dpc_c10",    d_pc,    32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
